// File: rtl/instr_sequencer.sv
// ---------------------------------------------------------------------------
// instr_sequencer
//   Loads instructions into an external synchronous-read memory one key press
//   at a time (rw=1). On a run press (rw=0) it reads the stored program back
//   in order and presents each instruction to an ALU with a valid/ready
//   handshake.
//
// Ports
//   clk, rst              clock and asynchronous active-high reset
//   key, rw, clr          push-button level, load/run mode, program clear
//   i_data                instruction captured on a load press
//   mem_addr/we/wdata     memory write/read request
//   mem_rdata             memory read data, one cycle after mem_addr
//   alu_valid, alu_ready  ALU handshake
//   instruction, A, B     decoded fields of the instruction being issued
//   count, full, empty    program length and its limits
//   busy, done            activity flag and end-of-run pulse
// ---------------------------------------------------------------------------
module instr_sequencer #(
    parameter int DEPTH = 8,
    parameter int AW    = 3,
    parameter int DW    = 15
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          key,
    input  logic          rw,
    input  logic          clr,
    input  logic [DW-1:0] i_data,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          alu_valid,
    input  logic          alu_ready,
    output logic [2:0]    instruction,
    output logic [5:0]    A,
    output logic [5:0]    B,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty,
    output logic          busy,
    output logic          done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_FETCH,
        S_WAIT,
        S_ISSUE,
        S_DONE
    } state_t;

    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);

    state_t        state_q, state_d;
    logic          key_q;
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic [DW-1:0] data_q;
    logic [2:0]    instr_q;
    logic [5:0]    a_q;
    logic [5:0]    b_q;

    logic key_pulse;
    logic start_load;
    logic start_run;
    logic last_item;
    logic handshake;

    assign key_pulse  = key & ~key_q;
    // Clear has priority over any press seen in the same IDLE cycle.
    assign start_load = (state_q == S_IDLE) && !clr && key_pulse && rw && !full;
    assign start_run  = (state_q == S_IDLE) && !clr && key_pulse && !rw && !empty;
    // count is never zero while a run is in progress, so count-1 is safe.
    assign last_item  = ({1'b0, rd_ptr_q} == (count_q - CNT_ONE));
    assign handshake  = (state_q == S_ISSUE) && alu_ready;

    assign full        = (count_q == CNT_FULL);
    assign empty       = (count_q == '0);
    assign count       = count_q;
    assign instruction = instr_q;
    assign A           = a_q;
    assign B           = b_q;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_load) begin
                    state_d = S_WRITE;
                end else if (start_run) begin
                    state_d = S_FETCH;
                end
            end
            S_WRITE: state_d = S_IDLE;
            S_FETCH: state_d = S_WAIT;
            S_WAIT:  state_d = S_ISSUE;
            S_ISSUE: begin
                if (alu_ready) begin
                    state_d = last_item ? S_DONE : S_FETCH;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        mem_we    = 1'b0;
        alu_valid = 1'b0;
        done      = 1'b0;
        busy      = (state_q != S_IDLE);
        mem_addr  = rd_ptr_q;
        mem_wdata = data_q;
        case (state_q)
            S_WRITE: begin
                mem_we   = 1'b1;
                mem_addr = wr_ptr_q;
            end
            S_ISSUE: alu_valid = 1'b1;
            S_DONE:  done      = 1'b1;
            default: ;
        endcase
    end

    // Datapath: pointers, count, captured data and the issued instruction
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // key_q resets high so a key held through reset gives no pulse
            key_q    <= 1'b1;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            data_q   <= '0;
            instr_q  <= '0;
            a_q      <= '0;
            b_q      <= '0;
        end else begin
            key_q <= key;
            if (state_q == S_IDLE && clr) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
            end
            if (start_load) begin
                data_q <= i_data;
            end
            if (start_run) begin
                rd_ptr_q <= '0;
            end
            if (state_q == S_WRITE) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
                count_q  <= count_q + CNT_ONE;
            end
            // Read data for rd_ptr is on mem_rdata during WAIT
            if (state_q == S_WAIT) begin
                instr_q <= mem_rdata[14:12];
                a_q     <= mem_rdata[11:6];
                b_q     <= mem_rdata[5:0];
            end
            if (handshake && !last_item) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// ---------------------------------------------------------------------------
// tb_instr_sequencer
//   Directed bench for instr_sequencer with a synchronous-read memory model.
//   Inputs are driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_instr_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        key;
    logic        rw;
    logic        clr;
    logic [14:0] i_data;
    logic [2:0]  mem_addr;
    logic        mem_we;
    logic [14:0] mem_wdata;
    logic [14:0] mem_rdata;
    logic        alu_valid;
    logic        alu_ready;
    logic [2:0]  instruction;
    logic [5:0]  A;
    logic [5:0]  B;
    logic [3:0]  count;
    logic        full;
    logic        empty;
    logic        busy;
    logic        done;

    always #5 clk = ~clk;

    instr_sequencer #(.DEPTH(8), .AW(3), .DW(15)) dut (
        .clk         (clk),
        .rst         (rst),
        .key         (key),
        .rw          (rw),
        .clr         (clr),
        .i_data      (i_data),
        .mem_addr    (mem_addr),
        .mem_we      (mem_we),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .alu_valid   (alu_valid),
        .alu_ready   (alu_ready),
        .instruction (instruction),
        .A           (A),
        .B           (B),
        .count       (count),
        .full        (full),
        .empty       (empty),
        .busy        (busy),
        .done        (done)
    );

    // Synchronous-read memory
    logic [14:0] mem [8];
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    int n_tests = 0;
    int n_fail  = 0;
    int done_cnt = 0;
    int exp_cnt  = 0;
    logic [14:0] exp_mem [8];

    always @(negedge clk) if (done === 1'b1) done_cnt++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // One load press; the bench model decides whether a write must happen.
    task automatic do_load(input logic [14:0] d);
        bit expect_write;
        expect_write = (exp_cnt < 8);
        @(negedge clk);
        i_data = d; rw = 1'b1; key = 1'b1;
        @(negedge clk);
        key = 1'b0;
        $display("[TB] load 0x%04h expect_write=%0d", d, expect_write);
        check("load_we", 32'(mem_we), 32'(expect_write));
        if (expect_write) begin
            check("load_addr",  32'(mem_addr),  exp_cnt);
            check("load_wdata", 32'(mem_wdata), 32'(d));
            exp_mem[exp_cnt] = d;
            exp_cnt++;
        end else begin
            check("load_busy_full", 32'(busy), 0);
        end
        @(negedge clk);
        check("load_we_off", 32'(mem_we), 0);
        check("load_count",  32'(count),  exp_cnt);
    endtask

    // One run press; item stall_item sees alu_ready low for stall_cycles cycles.
    task automatic do_run(input int n, input int stall_item, input int stall_cycles);
        int done_before;
        done_before = done_cnt;
        @(negedge clk);
        rw = 1'b0; key = 1'b1; alu_ready = 1'b1;
        @(negedge clk);
        key = 1'b0;
        for (int i = 0; i < n; i++) begin
            check("fetch_valid", 32'(alu_valid), 0);
            check("fetch_addr",  32'(mem_addr),  i);
            check("fetch_busy",  32'(busy),      1);
            @(negedge clk);
            check("wait_valid", 32'(alu_valid), 0);
            alu_ready = (i == stall_item) ? 1'b0 : 1'b1;
            @(negedge clk);
            $display("[TB] issue %0d: op=%0d A=%0d B=%0d", i, instruction, A, B);
            check("issue_valid", 32'(alu_valid),   1);
            check("issue_op",    32'(instruction), 32'(exp_mem[i][14:12]));
            check("issue_A",     32'(A),           32'(exp_mem[i][11:6]));
            check("issue_B",     32'(B),           32'(exp_mem[i][5:0]));
            if (i == stall_item) begin
                for (int s = 0; s < stall_cycles; s++) begin
                    @(negedge clk);
                    check("stall_valid", 32'(alu_valid),   1);
                    check("stall_op",    32'(instruction), 32'(exp_mem[i][14:12]));
                    check("stall_A",     32'(A),           32'(exp_mem[i][11:6]));
                    check("stall_B",     32'(B),           32'(exp_mem[i][5:0]));
                    check("stall_ptr",   32'(mem_addr),    i);
                end
                alu_ready = 1'b1;
            end
            @(negedge clk);
        end
        check("run_done",       32'(done),      1);
        check("run_done_valid", 32'(alu_valid), 0);
        @(negedge clk);
        check("run_done_off", 32'(done), 0);
        check("run_idle",     32'(busy), 0);
        check("run_done_cnt", done_cnt - done_before, 1);
        check("run_retain_op", 32'(instruction), 32'(exp_mem[n-1][14:12]));
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; key = 1'b1; rw = 1'b1; clr = 1'b0;
        i_data = '0; alu_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        $display("[TB] reset state");
        check("rst_mem_we", 32'(mem_we),      0);
        check("rst_addr",   32'(mem_addr),    0);
        check("rst_wdata",  32'(mem_wdata),   0);
        check("rst_valid",  32'(alu_valid),   0);
        check("rst_op",     32'(instruction), 0);
        check("rst_A",      32'(A),           0);
        check("rst_B",      32'(B),           0);
        check("rst_done",   32'(done),        0);
        check("rst_busy",   32'(busy),        0);
        check("rst_empty",  32'(empty),       1);
        check("rst_full",   32'(full),        0);
        check("rst_count",  32'(count),       0);
        rst = 1'b0;                       // key still high: no pulse expected
        @(negedge clk);
        check("rel_busy", 32'(busy),   0);
        check("rel_we",   32'(mem_we), 0);
        key = 1'b0;

        // Three loads then a three-item run with alu_ready high
        do_load(15'h1041);
        do_load(15'h2082);
        do_load(15'h30C3);
        check("three_empty", 32'(empty), 0);
        do_run(3, -1, 0);

        // Stall on the second item
        do_run(3, 1, 5);

        // Fill to eight, ninth press ignored, then read all back
        do_load(15'h4104);
        do_load(15'h5145);
        do_load(15'h6186);
        do_load(15'h71C7);
        do_load(15'h0208);
        check("eight_full", 32'(full), 1);
        do_load(15'h7FFF);
        check("nine_full",  32'(full),  1);
        check("nine_count", 32'(count), 8);
        do_run(8, -1, 0);

        // Clear, then a run press on an empty program
        @(negedge clk); clr = 1'b1;
        @(negedge clk); clr = 1'b0;
        exp_cnt = 0;
        $display("[TB] clear");
        check("clr_count", 32'(count), 0);
        check("clr_empty", 32'(empty), 1);
        check("clr_full",  32'(full),  0);
        @(negedge clk); rw = 1'b0; key = 1'b1;
        @(negedge clk); key = 1'b0;
        for (int c = 0; c < 4; c++) begin
            check("empty_run_busy",  32'(busy),      0);
            check("empty_run_valid", 32'(alu_valid), 0);
            @(negedge clk);
        end

        // Loads restart at address 0 after clear
        do_load(15'h2A15);
        do_load(15'h1555);

        // Reset in the middle of ISSUE
        @(negedge clk); rw = 1'b0; key = 1'b1; alu_ready = 1'b0;
        @(negedge clk); key = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("pre_rst_valid", 32'(alu_valid), 1);
        key = 1'b1;
        rst = 1'b1;
        #1;
        $display("[TB] reset during issue");
        check("midrst_valid", 32'(alu_valid), 0);
        check("midrst_busy",  32'(busy),      0);
        check("midrst_count", 32'(count),     0);
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        check("post_rst_busy",  32'(busy),   0);
        check("post_rst_we",    32'(mem_we), 0);
        @(negedge clk);
        check("post_rst_busy2", 32'(busy),   0);
        check("post_rst_count", 32'(count),  0);
        check("post_rst_empty", 32'(empty),  1);
        key = 1'b0; alu_ready = 1'b1;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
